// File: rtl/sigma_delta_decimator.sv
// Receive end of the 1-bit sigma-delta link: third-order CIC decimator recovering
// 16-bit offset-binary PCM, with a single-entry valid/ready output register.
module sigma_delta_decimator #(
  parameter int DECIM_LOG2 = 10,
  parameter int ACC_W      = 3 * DECIM_LOG2 + 1
) (
  input  logic        clk48,
  input  logic        rst,
  input  logic        pdm_in,
  output logic [15:0] sample,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        overrun
);

  localparam int SHIFT = 3 * DECIM_LOG2 - 16;
  localparam int PCM_W = ACC_W - SHIFT;
  localparam logic [DECIM_LOG2-1:0] CNT_ONE = 1;
  localparam logic [ACC_W-1:0] ACC_ZERO = '0;

  logic [ACC_W-1:0]      i1, i2, i3;
  logic [ACC_W-1:0]      i3_d, c1_d, c2_d;
  logic [ACC_W-1:0]      c1, c2, c3;
  logic [DECIM_LOG2-1:0] dec_cnt;
  logic [1:0]            prime_cnt;
  logic                  strobe;
  logic                  primed;
  logic [PCM_W-1:0]      pcm_full;
  logic [15:0]           pcm;

  assign strobe = &dec_cnt;
  assign primed = (prime_cnt == 2'd3);

  // Comb section works on the registered i3, i.e. the value before this edge's update.
  always_comb begin
    c1       = i3 - i3_d;
    c2       = c1 - c1_d;
    c3       = c2 - c2_d;
    pcm_full = PCM_W'(c3 >> SHIFT);
    // Only an exactly full-scale window reaches bit 16; clamp instead of wrapping to 0.
    if (|pcm_full[PCM_W-1:16]) begin
      pcm = 16'hFFFF;
    end else begin
      pcm = pcm_full[15:0];
    end
  end

  always_ff @(posedge clk48) begin
    if (rst) begin
      i1        <= '0;
      i2        <= '0;
      i3        <= '0;
      i3_d      <= '0;
      c1_d      <= '0;
      c2_d      <= '0;
      dec_cnt   <= '0;
      prime_cnt <= '0;
    end else begin
      i1      <= i1 + {ACC_ZERO[ACC_W-1:1], pdm_in};
      i2      <= i2 + i1;
      i3      <= i3 + i2;
      dec_cnt <= dec_cnt + CNT_ONE;
      if (strobe) begin
        i3_d <= i3;
        c1_d <= c1;
        c2_d <= c2;
        if (!primed) begin
          prime_cnt <= prime_cnt + 2'd1;
        end
      end
    end
  end

  // Handshake: a transfer happens on any edge where sample_valid && sample_ready.
  // A primed strobe always loads (reloading if the old value is consumed on the same
  // edge, flagging sticky overrun if it is not); otherwise a transfer clears valid.
  always_ff @(posedge clk48) begin
    if (rst) begin
      sample       <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else if (strobe && primed) begin
      sample       <= pcm;
      sample_valid <= 1'b1;
      if (sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end
    end else if (sample_valid && sample_ready) begin
      sample_valid <= 1'b0;
    end
  end

endmodule
